// File: rtl/vga_frame_lock_ctrl_pkg.sv
// Shared VGA timing constants, lock thresholds and types for the frame-lock controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_frame_lock_ctrl_pkg;

    // Generator timing; these must stay equal to the sync generator's own values.
    localparam logic [9:0] H_MAX         = 10'd799;
    localparam logic [9:0] V_SYNC_START  = 10'd490;

    // Lock acquisition and loss thresholds.
    localparam logic [9:0] LOCK_TOL      = 10'd8;
    localparam logic [2:0] LOCK_FRAMES   = 3'd4;
    localparam logic [8:0] TIMEOUT_LINES = 9'd400;
    localparam logic [8:0] LINE_MAX      = 9'd511;

    typedef logic [8:0] line_cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        LOCKED
    } state_t;

    // True when the VGA vertical position is within LOCK_TOL lines of natural vsync.
    function automatic logic vpos_in_tol(input logic [9:0] vpos);
        logic [9:0] err;
        err = (vpos >= V_SYNC_START) ? (vpos - V_SYNC_START) : (V_SYNC_START - vpos);
        return (err <= LOCK_TOL);
    endfunction

endpackage

// File: rtl/vga_frame_lock_ctrl_edge_pulse.sv
// Rising-edge detector for a level input in the core clock domain.
// Latency: o_rise is combinational in the cycle the input first reads high.
// Backpressure: none; the pulse is always one cycle wide.
module vga_frame_lock_ctrl_edge_pulse (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_rise
);

    logic r_sig_q;

    // Remember the previous level so a rise can be seen against it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sig_q <= 1'b0;
        end else begin
            r_sig_q <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_sig_q;

endmodule

// File: rtl/vga_frame_lock_ctrl.sv
// Locks the free-running VGA generator to the TIA frame and steers line-buffer banks.
// Latency: every output is registered; a TIA VSYNC rise acts on the following clock edge.
// Backpressure: none; TIA and VGA pulses are consumed in the cycle they appear.
module vga_frame_lock_ctrl
    import vga_frame_lock_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tia_vsync,
    input  logic       i_tia_line,
    input  logic [9:0] i_vga_hpos,
    input  logic [9:0] i_vga_vpos,
    output logic       o_force_vsync,
    output logic       o_wr_bank,
    output logic       o_rd_bank,
    output logic [8:0] o_wr_line,
    output logic [8:0] o_lines_per_frame,
    output logic       o_locked
);

    logic       w_vs_rise;
    logic       w_line_end;
    logic       w_in_tol;
    logic       w_timeout;

    line_cnt_t  r_wr_line;
    line_cnt_t  r_lines_per_frame;
    logic       r_wr_bank;
    logic       r_rd_bank;
    logic       r_force_vsync;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_lock_cnt;
    logic [2:0] w_lock_cnt_nxt;
    logic       r_locked;
    logic       w_locked_nxt;

    vga_frame_lock_ctrl_edge_pulse u_vsync_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_sig  (i_tia_vsync),
        .o_rise (w_vs_rise)
    );

    assign w_line_end = (i_vga_hpos == H_MAX);
    assign w_in_tol   = vpos_in_tol(i_vga_vpos);

    // Timeout fires once, on the strobe that carries wr_line up to TIMEOUT_LINES.
    assign w_timeout  = i_tia_line & ~w_vs_rise & (r_wr_line == (TIMEOUT_LINES - 9'd1));

    // TIA line counting and write bank; a VSYNC rise restarts the count and wins over a strobe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_line         <= '0;
            r_lines_per_frame <= '0;
            r_wr_bank         <= 1'b0;
        end else begin
            if (w_vs_rise) begin
                r_lines_per_frame <= r_wr_line;
                r_wr_line         <= '0;
            end else if (i_tia_line && (r_wr_line != LINE_MAX)) begin
                r_wr_line <= r_wr_line + 9'd1;
            end
            if (i_tia_line) begin
                r_wr_bank <= ~r_wr_bank;
            end
        end
    end

    // VGA reads the bank the TIA is not writing, switching only at line end.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_bank <= 1'b1;
        end else if (w_line_end) begin
            r_rd_bank <= ~r_wr_bank;
        end
    end

    // One-shot force request: armed by an early VSYNC, dropped after a single line-end sample.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_force_vsync <= 1'b0;
        end else if (w_timeout) begin
            r_force_vsync <= 1'b0;
        end else if (r_force_vsync) begin
            if (w_line_end) begin
                r_force_vsync <= 1'b0;
            end
        end else if (w_vs_rise && (i_vga_vpos < V_SYNC_START)) begin
            r_force_vsync <= 1'b1;
        end
    end

    // Lock FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_locked   <= w_locked_nxt;
        end
    end

    // Lock FSM next state; it only moves on a VSYNC rise or a line-count timeout.
    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        w_locked_nxt   = r_locked;
        if (w_timeout) begin
            w_state_nxt    = IDLE;
            w_lock_cnt_nxt = '0;
            w_locked_nxt   = 1'b0;
        end else if (w_vs_rise) begin
            case (r_state)
                IDLE: begin
                    w_state_nxt    = TRACK;
                    w_lock_cnt_nxt = '0;
                    w_locked_nxt   = 1'b0;
                end
                TRACK: begin
                    if (w_in_tol) begin
                        w_lock_cnt_nxt = r_lock_cnt + 3'd1;
                        if (r_lock_cnt == (LOCK_FRAMES - 3'd1)) begin
                            w_state_nxt  = LOCKED;
                            w_locked_nxt = 1'b1;
                        end
                    end else begin
                        w_lock_cnt_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (!w_in_tol) begin
                        w_state_nxt    = TRACK;
                        w_lock_cnt_nxt = '0;
                        w_locked_nxt   = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt    = IDLE;
                    w_lock_cnt_nxt = '0;
                    w_locked_nxt   = 1'b0;
                end
            endcase
        end
    end

    assign o_force_vsync     = r_force_vsync;
    assign o_wr_bank         = r_wr_bank;
    assign o_rd_bank         = r_rd_bank;
    assign o_wr_line         = r_wr_line;
    assign o_lines_per_frame = r_lines_per_frame;
    assign o_locked          = r_locked;

endmodule

// File: tb/tb_vga_frame_lock_ctrl.sv
// Bench for the VGA frame-lock controller: directed scenarios plus random traffic vs a reference model.
// Latency: outputs compared 1 time unit after each rising clock edge.
// Backpressure: none.
module tb_vga_frame_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tia_vsync;
    logic       tia_line;
    logic [9:0] vga_hpos;
    logic [9:0] vga_vpos;
    logic       force_vsync;
    logic       wr_bank;
    logic       rd_bank;
    logic [8:0] wr_line;
    logic [8:0] lines_per_frame;
    logic       locked;

    always #5 clk = ~clk;

    vga_frame_lock_ctrl dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_tia_vsync       (tia_vsync),
        .i_tia_line        (tia_line),
        .i_vga_hpos        (vga_hpos),
        .i_vga_vpos        (vga_vpos),
        .o_force_vsync     (force_vsync),
        .o_wr_bank         (wr_bank),
        .o_rd_bank         (rd_bank),
        .o_wr_line         (wr_line),
        .o_lines_per_frame (lines_per_frame),
        .o_locked          (locked)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: frame-level rules with plain integers.
    // m_mode: 0 = waiting for first VSYNC, 1 = counting good frames, 2 = locked.
    int m_vsq, m_line, m_lpf, m_wb, m_rb, m_force, m_mode, m_good;

    task automatic m_reset();
        m_vsq = 0; m_line = 0; m_lpf = 0; m_wb = 0; m_rb = 1;
        m_force = 0; m_mode = 0; m_good = 0;
    endtask

    task automatic model_step(input int vs, input int ln, input int h, input int v);
        int rise, nl, to, err, tol;
        rise = (vs != 0) && (m_vsq == 0);
        if (rise) nl = 0;
        else if (ln != 0) nl = (m_line < 511) ? m_line + 1 : 511;
        else nl = m_line;
        to = (nl == 400) && (m_line != 400);
        err = v - 490;
        if (err < 0) err = -err;
        tol = (err <= 8);
        if (h == 799) m_rb = (m_wb == 0) ? 1 : 0;
        if (rise) m_lpf = m_line;
        m_line = nl;
        if (ln != 0) m_wb = (m_wb == 0) ? 1 : 0;
        if (to) m_force = 0;
        else if (m_force != 0) m_force = (h != 799) ? 1 : 0;
        else m_force = (rise && v < 490) ? 1 : 0;
        if (to) begin
            m_mode = 0; m_good = 0;
        end else if (rise) begin
            if (m_mode == 0) begin
                m_mode = 1; m_good = 0;
            end else if (m_mode == 1) begin
                if (tol) begin
                    m_good = m_good + 1;
                    if (m_good == 4) m_mode = 2;
                end else begin
                    m_good = 0;
                end
            end else if (!tol) begin
                m_mode = 1; m_good = 0;
            end
        end
        m_vsq = vs;
    endtask

    task automatic check_all();
        chk("wr_line", wr_line, m_line);
        chk("lines_per_frame", lines_per_frame, m_lpf);
        chk("wr_bank", wr_bank, m_wb);
        chk("rd_bank", rd_bank, m_rb);
        chk("force_vsync", force_vsync, m_force);
        chk("locked", locked, (m_mode == 2) ? 1 : 0);
    endtask

    // One clock cycle: drive inputs, advance the model, compare after the edge.
    task automatic cyc(input int vs, input int ln, input int h, input int v);
        tia_vsync = (vs != 0);
        tia_line  = (ln != 0);
        vga_hpos  = h[9:0];
        vga_vpos  = v[9:0];
        model_step(vs, ln, h, v);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic lines(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 100 + (i % 600), 50);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_force"}, force_vsync, 0);
        chk({tag, "_wr_bank"}, wr_bank, 0);
        chk({tag, "_rd_bank"}, rd_bank, 1);
        chk({tag, "_wr_line"}, wr_line, 0);
        chk({tag, "_lpf"}, lines_per_frame, 0);
        chk({tag, "_locked"}, locked, 0);
    endtask

    initial begin
        int vs_lvl, ln, h, v, sel, rate;
        rst = 1'b1; tia_vsync = 1'b0; tia_line = 1'b0; vga_hpos = '0; vga_vpos = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("por");
        rst = 1'b0;

        // Count a 262-line frame, then an early VSYNC forces one line-end sample.
        lines(262);
        cyc(1, 0, 300, 100);
        chk("t2_lpf", lines_per_frame, 262);
        chk("t2_wr_line", wr_line, 0);
        chk("t2_force_set", force_vsync, 1);
        cyc(0, 0, 500, 100);
        chk("t2_force_held", force_vsync, 1);
        cyc(0, 0, 799, 100);
        chk("t2_force_clr", force_vsync, 0);

        // Four in-tolerance frames lock, an out-of-tolerance frame unlocks.
        for (int f = 0; f < 4; f++) begin
            lines(10);
            cyc(1, 0, 300, 486);
            cyc(0, 0, 799, 486);
        end
        chk("t3_locked", locked, 1);
        lines(10);
        cyc(1, 0, 300, 200);
        chk("t3_unlock", locked, 0);
        cyc(0, 0, 799, 200);

        // VSYNC inside the natural sync region: no force, still in tolerance.
        for (int f = 0; f < 4; f++) begin
            lines(3);
            cyc(1, 0, 300, 495);
            chk("t4_no_force", force_vsync, 0);
            cyc(0, 0, 799, 495);
        end
        chk("t4_locked", locked, 1);

        // VSYNC and line strobe together; a second VSYNC while force is pending.
        lines(3);
        cyc(1, 1, 300, 100);
        chk("t5_wr_line", wr_line, 0);
        chk("t5_force", force_vsync, 1);
        cyc(0, 0, 301, 100);
        cyc(1, 0, 302, 100);
        chk("t5_force_pend", force_vsync, 1);
        cyc(0, 0, 799, 100);
        chk("t5_force_clr", force_vsync, 0);
        cyc(0, 0, 5, 100);
        cyc(0, 0, 799, 100);
        chk("t5_single_force", force_vsync, 0);

        // Lock, then starve VSYNC past the timeout and into saturation.
        for (int f = 0; f < 5; f++) begin
            lines(4);
            cyc(1, 0, 300, 489);
            cyc(0, 0, 799, 489);
        end
        chk("t6_prelock", locked, 1);
        lines(520);
        chk("t6_locked", locked, 0);
        chk("t6_sat", wr_line, 511);
        // From IDLE the first VSYNC only starts tracking: four more frames are needed.
        for (int f = 0; f < 4; f++) begin
            lines(4);
            cyc(1, 0, 300, 486);
            cyc(0, 0, 799, 486);
        end
        chk("t6_idle_nolock", locked, 0);
        lines(4);
        cyc(1, 0, 300, 486);
        chk("t1_pre_locked", locked, 1);
        chk("t1_pre_force", force_vsync, 1);

        // Asynchronous reset mid-cycle.
        tia_vsync = 1'b0; tia_line = 1'b0; vga_hpos = 10'd10;
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async");
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random traffic: frequent then rare VSYNC so both locking and timeouts occur.
        for (int p = 0; p < 2; p++) begin
            rate = (p == 0) ? 60 : 900;
            vs_lvl = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, rate - 1) == 0) vs_lvl = 1 - vs_lvl;
                ln = ($urandom_range(0, 3) == 0) ? 1 : 0;
                h = ($urandom_range(0, 5) == 0) ? 799 : int'($urandom_range(0, 798));
                sel = $urandom_range(0, 2);
                if (sel == 0) v = 482 + int'($urandom_range(0, 16));
                else if (sel == 1) v = int'($urandom_range(0, 524));
                else v = 480 + int'($urandom_range(0, 19));
                cyc(vs_lvl, ln, h, v);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
